sdrc_r2b_resp: RTL and testbench

Responder end of the request-generator to bank-control interface. It accepts r2b_* request chunks with a b2r_ack/b2r_arb_ok handshake and stores them in a small in-order queue. It presents the queue head to the bank scheduler as a valid/ready stream. It also tracks the open row of each bank, to produce a row-hit hint, and checks start/last framing of the chunk stream.

---
 rtl/sdrc_define.sv | 16 +
 rtl/sdrc_sync_fifo_fwft.sv | 60 ++++++
 rtl/sdrc_r2b_resp.sv | 120 ++++++++++++
 tb/tb_sdrc_r2b_resp.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_define.sv
// Shared SDRAM controller constants and the r2b queue entry layout.
package sdrc_define;

   localparam int SDR_REQ_ID_W = 4;
   localparam int REQ_BW       = 12;
   localparam int SDR_FLAG_W   = 4;
   localparam int SDR_BA_W     = 2;
   localparam int SDR_ROW_W    = 13;
   localparam int SDR_COL_W    = 13;

   // Entry packing order, MSB first: {id, start, last, wrap, write, ba, raddr, caddr, len}
   function automatic int r2b_entry_w(input int id_w, input int len_w);
      return id_w + SDR_FLAG_W + SDR_BA_W + SDR_ROW_W + SDR_COL_W + len_w;
   endfunction

endpackage

// File: rtl/sdrc_sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; head word is visible on dout whenever count != 0.
module sdrc_sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             do_push, do_pop;

   assign do_push = push & (count_q != FULL_CNT);
   assign do_pop  = pop & (count_q != '0);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage carries no reset; only the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/sdrc_r2b_resp.sv
// Responder side of the request-generator to bank-control link: chunk queue,
// open-row tracking for a row-hit hint, and start/last framing checker.
module sdrc_r2b_resp import sdrc_define::*; #(
   parameter int REQ_ID_W = SDR_REQ_ID_W,
   parameter int REQ_BW   = sdrc_define::REQ_BW,
   parameter int DEPTH    = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                r2b_req,
   input  logic [REQ_ID_W-1:0] r2b_req_id,
   input  logic                r2b_start,
   input  logic                r2b_last,
   input  logic                r2b_wrap,
   input  logic                r2b_write,
   input  logic [1:0]          r2b_ba,
   input  logic [12:0]         r2b_raddr,
   input  logic [12:0]         r2b_caddr,
   input  logic [REQ_BW-1:0]   r2b_len,
   output logic                b2r_ack,
   output logic                b2r_arb_ok,
   output logic                bk_valid,
   input  logic                bk_ready,
   output logic [REQ_ID_W-1:0] bk_req_id,
   output logic                bk_start,
   output logic                bk_last,
   output logic                bk_wrap,
   output logic                bk_write,
   output logic [1:0]          bk_ba,
   output logic [12:0]         bk_raddr,
   output logic [12:0]         bk_caddr,
   output logic [REQ_BW-1:0]   bk_len,
   output logic                bk_row_hit,
   input  logic                bk_pre_all,
   output logic                r2b_idle,
   output logic                proto_err
);

   localparam int          AW       = $clog2(DEPTH);
   localparam int          EW       = r2b_entry_w(REQ_ID_W, REQ_BW);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] TWO_CNT  = (AW+1)'(2);

   logic [AW:0]   count;
   logic [EW-1:0] push_ent, head_ent;
   logic          pop;

   logic [12:0]   open_row_q [4];
   logic [3:0]    open_vld_q, open_vld_d;
   logic          burst_open_q, burst_open_d;
   logic          proto_err_q, proto_err_d;

   // No full bypass: a full queue refuses even if the head is leaving this cycle.
   assign b2r_ack    = reset_n & r2b_req & (count != FULL_CNT);
   // Two free slots guarantee the second half of a page-split request fits.
   assign b2r_arb_ok = (FULL_CNT - count) >= TWO_CNT;
   assign bk_valid   = (count != '0);
   assign pop        = bk_valid & bk_ready;
   assign r2b_idle   = (count == '0) & ~r2b_req;

   assign push_ent = {r2b_req_id, r2b_start, r2b_last, r2b_wrap, r2b_write,
                      r2b_ba, r2b_raddr, r2b_caddr, r2b_len};
   assign {bk_req_id, bk_start, bk_last, bk_wrap, bk_write,
           bk_ba, bk_raddr, bk_caddr, bk_len} = head_ent;

   sdrc_sync_fifo_fwft #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .push    (b2r_ack),
      .pop     (pop),
      .din     (push_ent),
      .dout    (head_ent),
      .count   (count)
   );

   // Precharge-all clears every bank first, so a coincident pop still marks its own bank open.
   always_comb begin
      open_vld_d = open_vld_q;
      if (bk_pre_all) open_vld_d = '0;
      if (pop)        open_vld_d[bk_ba] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) open_vld_q <= '0;
      else          open_vld_q <= open_vld_d;
   end

   always_ff @(posedge clk) begin
      if (pop) open_row_q[bk_ba] <= bk_raddr;
   end

   assign bk_row_hit = bk_valid & open_vld_q[bk_ba] & (open_row_q[bk_ba] == bk_raddr);

   // A start chunk is legal only outside a burst and a continuation only inside one,
   // so an error is exactly start == burst_open.
   always_comb begin
      burst_open_d = burst_open_q;
      proto_err_d  = proto_err_q;
      if (b2r_ack) begin
         if (r2b_start == burst_open_q) proto_err_d = 1'b1;
         burst_open_d = ~r2b_last;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         burst_open_q <= 1'b0;
         proto_err_q  <= 1'b0;
      end else begin
         burst_open_q <= burst_open_d;
         proto_err_q  <= proto_err_d;
      end
   end

   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_sdrc_r2b_resp.sv
// Directed bench for sdrc_r2b_resp with a queue-based reference model checked every cycle.
module tb_sdrc_r2b_resp;

   localparam int DEPTH = 4;

   typedef struct packed {
      logic [3:0]  id;
      logic        start;
      logic        last;
      logic        wrap;
      logic        write;
      logic [1:0]  ba;
      logic [12:0] raddr;
      logic [12:0] caddr;
      logic [11:0] len;
   } ent_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        r2b_req;
   ent_t        cur;
   logic        b2r_ack, b2r_arb_ok, bk_valid, bk_ready;
   logic [3:0]  bk_req_id;
   logic        bk_start, bk_last, bk_wrap, bk_write;
   logic [1:0]  bk_ba;
   logic [12:0] bk_raddr, bk_caddr;
   logic [11:0] bk_len;
   logic        bk_row_hit, bk_pre_all, r2b_idle, proto_err;

   always #5 clk = ~clk;

   sdrc_r2b_resp #(.REQ_ID_W(4), .REQ_BW(12), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .r2b_req    (r2b_req),
      .r2b_req_id (cur.id),
      .r2b_start  (cur.start),
      .r2b_last   (cur.last),
      .r2b_wrap   (cur.wrap),
      .r2b_write  (cur.write),
      .r2b_ba     (cur.ba),
      .r2b_raddr  (cur.raddr),
      .r2b_caddr  (cur.caddr),
      .r2b_len    (cur.len),
      .b2r_ack    (b2r_ack),
      .b2r_arb_ok (b2r_arb_ok),
      .bk_valid   (bk_valid),
      .bk_ready   (bk_ready),
      .bk_req_id  (bk_req_id),
      .bk_start   (bk_start),
      .bk_last    (bk_last),
      .bk_wrap    (bk_wrap),
      .bk_write   (bk_write),
      .bk_ba      (bk_ba),
      .bk_raddr   (bk_raddr),
      .bk_caddr   (bk_caddr),
      .bk_len     (bk_len),
      .bk_row_hit (bk_row_hit),
      .bk_pre_all (bk_pre_all),
      .r2b_idle   (r2b_idle),
      .proto_err  (proto_err)
   );

   int   checks = 0;
   int   errors = 0;
   bit   cmp_en = 1'b0;

   ent_t        mq[$];
   logic [12:0] m_row [4] = '{default: '0};
   logic [3:0]  m_vld = '0;
   bit          m_burst = 1'b0;
   bit          m_err = 1'b0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
      end
   endtask

   function automatic ent_t mk(int id, int st, int la, int ba, int ra, int ca, int ln);
      ent_t e;
      e.id    = 4'(id);
      e.start = 1'(st);
      e.last  = 1'(la);
      e.wrap  = 1'(id);
      e.write = 1'(id >> 1);
      e.ba    = 2'(ba);
      e.raddr = 13'(ra);
      e.caddr = 13'(ca);
      e.len   = 12'(ln);
      return e;
   endfunction

   // Reference model: transaction-level queue plus per-bank open-row bookkeeping.
   always @(posedge clk) begin : model
      bit   acc, pp;
      ent_t h;
      if (!reset_n) begin
         mq.delete();
         m_vld   = '0;
         m_burst = 1'b0;
         m_err   = 1'b0;
      end else begin
         acc = r2b_req && (mq.size() < DEPTH);
         pp  = (mq.size() != 0) && bk_ready;
         if (bk_pre_all) m_vld = '0;
         if (pp) begin
            h = mq.pop_front();
            m_row[h.ba] = h.raddr;
            m_vld[h.ba] = 1'b1;
         end
         if (acc) begin
            if ((cur.start && m_burst) || (!cur.start && !m_burst)) m_err = 1'b1;
            m_burst = !cur.last;
            mq.push_back(cur);
         end
      end
   end

   always @(negedge clk) begin : compare
      int   n;
      ent_t h;
      if (cmp_en) begin
         n = mq.size();
         check("ack", b2r_ack, reset_n && r2b_req && (n < DEPTH));
         check("arb_ok", b2r_arb_ok, (DEPTH - n) >= 2);
         check("valid", bk_valid, n != 0);
         check("idle", r2b_idle, (n == 0) && !r2b_req);
         check("proto_err", proto_err, m_err);
         if (n != 0) begin
            h = mq[0];
            check("head", {bk_req_id, bk_start, bk_last, bk_wrap, bk_write,
                           bk_ba, bk_raddr, bk_caddr, bk_len}, h);
            check("row_hit", bk_row_hit, m_vld[h.ba] && (m_row[h.ba] == h.raddr));
         end else begin
            check("row_hit_empty", bk_row_hit, 0);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic push1(input ent_t e);
      cur     = e;
      r2b_req = 1'b1;
      cyc();
      r2b_req = 1'b0;
   endtask

   task automatic drain(input int n);
      bk_ready = 1'b1;
      repeat (n) cyc();
      bk_ready = 1'b0;
   endtask

   initial begin
      reset_n    = 1'b0;
      r2b_req    = 1'b0;
      cur        = '0;
      bk_ready   = 1'b0;
      bk_pre_all = 1'b0;
      cyc();
      @(negedge clk);
      check("rst_valid", bk_valid, 0);
      check("rst_ack", b2r_ack, 0);
      check("rst_arb_ok", b2r_arb_ok, 1);
      check("rst_idle", r2b_idle, 1);
      check("rst_proto_err", proto_err, 0);
      check("rst_row_hit", bk_row_hit, 0);
      cyc();
      reset_n = 1'b1;
      cmp_en  = 1'b1;

      // Single chunk
      cur     = mk(1, 1, 1, 2, 'h0A5, 'h010, 4);
      r2b_req = 1'b1;
      @(negedge clk);
      check("single_ack", b2r_ack, 1);
      cyc();
      r2b_req = 1'b0;
      @(negedge clk);
      check("single_valid", bk_valid, 1);
      check("single_ba", bk_ba, 2);
      check("single_raddr", bk_raddr, 'h0A5);
      check("single_caddr", bk_caddr, 'h010);
      check("single_len", bk_len, 4);
      check("single_row_hit", bk_row_hit, 0);
      check("single_arb_ok", b2r_arb_ok, 1);
      cyc();
      drain(1);

      // Split request on top of two queued entries
      push1(mk(2, 1, 1, 0, 1, 0, 1));
      push1(mk(3, 1, 1, 0, 2, 0, 1));
      cur     = mk(4, 1, 0, 1, 'h100, 'h040, 'h20);
      r2b_req = 1'b1;
      @(negedge clk);
      check("split_arb_ok_pre", b2r_arb_ok, 1);
      check("split_ack1", b2r_ack, 1);
      cyc();
      cur = mk(5, 0, 1, 1, 'h100, 0, 'h10);
      @(negedge clk);
      check("split_arb_ok_cnt3", b2r_arb_ok, 0);
      check("split_ack2", b2r_ack, 1);
      cyc();
      r2b_req = 1'b0;
      @(negedge clk);
      check("split_proto_err", proto_err, 0);
      cyc();
      drain(4);

      // Full queue: no ack even with a concurrent pop
      for (int i = 0; i < 4; i++) push1(mk(8 + i, 1, 1, i, i * 16, 0, 1));
      cur      = mk(12, 1, 1, 3, 'h30, 0, 1);
      r2b_req  = 1'b1;
      bk_ready = 1'b1;
      @(negedge clk);
      check("full_no_ack", b2r_ack, 0);
      cyc();
      bk_ready = 1'b0;
      @(negedge clk);
      check("full_ack_next", b2r_ack, 1);
      check("full_head_order", bk_req_id, 9);
      cyc();
      r2b_req = 1'b0;
      drain(4);

      // Row hit and precharge-all
      push1(mk(13, 1, 1, 1, 'h123, 0, 1));
      push1(mk(14, 1, 1, 1, 'h123, 4, 1));
      @(negedge clk);
      check("rowhit_stale_row", bk_row_hit, 0);
      cyc();
      drain(1);
      @(negedge clk);
      check("rowhit_same_row", bk_row_hit, 1);
      cyc();
      bk_pre_all = 1'b1;
      cyc();
      bk_pre_all = 1'b0;
      @(negedge clk);
      check("rowhit_after_pre_all", bk_row_hit, 0);
      cyc();
      push1(mk(15, 1, 1, 3, 'h077, 0, 1));
      push1(mk(0, 1, 1, 1, 'h123, 8, 1));
      push1(mk(1, 1, 1, 3, 'h077, 8, 1));
      bk_ready = 1'b1;
      cyc();
      bk_pre_all = 1'b1;
      cyc();
      bk_ready   = 1'b0;
      bk_pre_all = 1'b0;
      @(negedge clk);
      check("pop_pre_all_head", bk_req_id, 0);
      check("pop_pre_all_other_bank", bk_row_hit, 0);
      cyc();
      drain(1);
      @(negedge clk);
      check("pop_pre_all_own_bank", bk_row_hit, 1);
      cyc();
      drain(1);

      // Framing: two starts without a last
      push1(mk(2, 1, 0, 0, 5, 0, 1));
      @(negedge clk);
      check("frame_first_ok", proto_err, 0);
      cyc();
      push1(mk(3, 1, 0, 0, 5, 0, 1));
      @(negedge clk);
      check("frame_double_start", proto_err, 1);
      cyc();
      drain(2);
      repeat (3) cyc();
      @(negedge clk);
      check("frame_sticky", proto_err, 1);
      cyc();

      // Reset with entries queued
      push1(mk(4, 1, 1, 0, 1, 0, 1));
      push1(mk(5, 1, 1, 1, 2, 0, 1));
      push1(mk(6, 1, 1, 2, 3, 0, 1));
      reset_n = 1'b0;
      cyc();
      reset_n = 1'b1;
      @(negedge clk);
      check("mid_rst_valid", bk_valid, 0);
      check("mid_rst_arb_ok", b2r_arb_ok, 1);
      check("mid_rst_idle", r2b_idle, 1);
      check("mid_rst_proto_err", proto_err, 0);
      cyc();
      push1(mk(7, 1, 1, 3, 'h077, 0, 1));
      @(negedge clk);
      check("mid_rst_valid_again", bk_valid, 1);
      check("mid_rst_open_rows_cleared", bk_row_hit, 0);
      cyc();
      drain(1);
      repeat (2) cyc();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
